// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage pipelined CPU.
// Holds the datapath and register-address widths, the decoded control
// bundle carried down the pipe, the all-zero bubble control word and the
// writeback-select encodings.
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    // Writeback select encodings
    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MEM = 2'd1;
    localparam logic [1:0] MTR_PC4 = 2'd2;

    typedef struct packed {
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic [5:0] alu_fun;
        logic       branch;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'(13'b0);

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector.
// Flags when the instruction in EX is a load whose destination is read by
// the instruction currently in ID, so the load result cannot be forwarded
// in time.
// Ports:
//   MemRd_ID_EX, AddrC_ID_EX : load flag and destination of the EX instruction
//   Rs_ID, Rt_ID, UseRt_ID   : sources of the ID instruction
//   LU                       : combinational hazard flag
module hazard_detect
    import cpu_pkg::*;
(
    input  logic          MemRd_ID_EX,
    input  logic [AW-1:0] AddrC_ID_EX,
    input  logic [AW-1:0] Rs_ID,
    input  logic [AW-1:0] Rt_ID,
    input  logic          UseRt_ID,
    output logic          LU
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = (AddrC_ID_EX == Rs_ID);
    // Rt only matters when the ID instruction actually reads it
    assign rt_hit_s = UseRt_ID && (AddrC_ID_EX == Rt_ID);
    // A load to $0 produces nothing worth waiting for
    assign LU = MemRd_ID_EX && (AddrC_ID_EX != {AW{1'b0}}) && (rs_hit_s || rt_hit_s);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and branch/jump flush.
// Captures ID operands, register numbers and control each cycle, or loads
// a bubble on flush or load-use hazard. Stall freezes PC and IF/ID for the
// hazard cycle; StallCnt counts hazard cycles, saturating at all-ones.
// Ports:
//   clk, reset (synchronous, active-low)
//   *_ID inputs        : decoded instruction from ID
//   Flush              : discard the ID instruction
//   *_ID_EX outputs    : registered copy presented to EX / forwarding unit
//   Stall              : combinational hold for PC and IF/ID
//   StallCnt           : saturating load-use stall count
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DW    = cpu_pkg::DW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DW-1:0]    PC4_ID,
    input  logic [DW-1:0]    DataA_ID,
    input  logic [DW-1:0]    DataB_ID,
    input  logic [DW-1:0]    Imm_ID,
    input  logic [AW-1:0]    Rs_ID,
    input  logic [AW-1:0]    Rt_ID,
    input  logic [AW-1:0]    AddrC_ID,
    input  logic             UseRt_ID,
    input  logic             RegWr_ID,
    input  logic             MemRd_ID,
    input  logic             MemWr_ID,
    input  logic             ALUSrc_ID,
    input  logic             Branch_ID,
    input  logic [1:0]       MemToReg_ID,
    input  logic [5:0]       ALUFun_ID,
    input  logic             Flush,
    output logic [DW-1:0]    PC4_ID_EX,
    output logic [DW-1:0]    DataA_ID_EX,
    output logic [DW-1:0]    DataB_ID_EX,
    output logic [DW-1:0]    Imm_ID_EX,
    output logic [AW-1:0]    Rs_ID_EX,
    output logic [AW-1:0]    Rt_ID_EX,
    output logic [AW-1:0]    AddrC_ID_EX,
    output logic             UseRt_ID_EX,
    output logic             RegWr_ID_EX,
    output logic             MemRd_ID_EX,
    output logic             MemWr_ID_EX,
    output logic             ALUSrc_ID_EX,
    output logic             Branch_ID_EX,
    output logic [1:0]       MemToReg_ID_EX,
    output logic [5:0]       ALUFun_ID_EX,
    output logic             Stall,
    output logic [CNT_W-1:0] StallCnt
);

    logic [DW-1:0]    pc4_d, pc4_q;
    logic [DW-1:0]    data_a_d, data_a_q;
    logic [DW-1:0]    data_b_d, data_b_q;
    logic [DW-1:0]    imm_d, imm_q;
    logic [AW-1:0]    rs_d, rs_q;
    logic [AW-1:0]    rt_d, rt_q;
    logic [AW-1:0]    addr_c_d, addr_c_q;
    logic             use_rt_d, use_rt_q;
    ctrl_t            ctrl_d, ctrl_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    ctrl_t            ctrl_in_s;
    logic             lu_s;

    assign ctrl_in_s = '{reg_wr: RegWr_ID, mem_rd: MemRd_ID, mem_wr: MemWr_ID,
                         mem_to_reg: MemToReg_ID, alu_src: ALUSrc_ID,
                         alu_fun: ALUFun_ID, branch: Branch_ID};

    hazard_detect u_hazard_detect (
        .MemRd_ID_EX (ctrl_q.mem_rd),
        .AddrC_ID_EX (addr_c_q),
        .Rs_ID       (Rs_ID),
        .Rt_ID       (Rt_ID),
        .UseRt_ID    (UseRt_ID),
        .LU          (lu_s)
    );

    // A flushed instruction is discarded anyway, so holding IF/ID is pointless
    assign Stall = lu_s && !Flush;

    // Next-state selection: flush or hazard loads a bubble, else capture ID
    always_comb begin
        pc4_d       = {DW{1'b0}};
        data_a_d    = {DW{1'b0}};
        data_b_d    = {DW{1'b0}};
        imm_d       = {DW{1'b0}};
        rs_d        = {AW{1'b0}};
        rt_d        = {AW{1'b0}};
        addr_c_d    = {AW{1'b0}};
        use_rt_d    = 1'b0;
        ctrl_d      = CTRL_NOP;
        stall_cnt_d = stall_cnt_q;
        if (Flush) begin
            stall_cnt_d = stall_cnt_q;
        end else if (lu_s) begin
            if (stall_cnt_q != {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end else begin
                stall_cnt_d = stall_cnt_q;
            end
        end else begin
            pc4_d    = PC4_ID;
            data_a_d = DataA_ID;
            data_b_d = DataB_ID;
            imm_d    = Imm_ID;
            rs_d     = Rs_ID;
            rt_d     = Rt_ID;
            addr_c_d = AddrC_ID;
            use_rt_d = UseRt_ID;
            ctrl_d   = ctrl_in_s;
        end
    end

    // Pipeline and counter registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc4_q       <= {DW{1'b0}};
            data_a_q    <= {DW{1'b0}};
            data_b_q    <= {DW{1'b0}};
            imm_q       <= {DW{1'b0}};
            rs_q        <= {AW{1'b0}};
            rt_q        <= {AW{1'b0}};
            addr_c_q    <= {AW{1'b0}};
            use_rt_q    <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc4_q       <= pc4_d;
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            addr_c_q    <= addr_c_d;
            use_rt_q    <= use_rt_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign PC4_ID_EX      = pc4_q;
    assign DataA_ID_EX    = data_a_q;
    assign DataB_ID_EX    = data_b_q;
    assign Imm_ID_EX      = imm_q;
    assign Rs_ID_EX       = rs_q;
    assign Rt_ID_EX       = rt_q;
    assign AddrC_ID_EX    = addr_c_q;
    assign UseRt_ID_EX    = use_rt_q;
    assign RegWr_ID_EX    = ctrl_q.reg_wr;
    assign MemRd_ID_EX    = ctrl_q.mem_rd;
    assign MemWr_ID_EX    = ctrl_q.mem_wr;
    assign ALUSrc_ID_EX   = ctrl_q.alu_src;
    assign Branch_ID_EX   = ctrl_q.branch;
    assign MemToReg_ID_EX = ctrl_q.mem_to_reg;
    assign ALUFun_ID_EX   = ctrl_q.alu_fun;
    assign StallCnt       = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a driver issues one ID instruction per
// cycle and pushes the expected Stall / next EX contents / StallCnt; a
// monitor checks Stall before the edge and the registers after it.
module tb_id_ex_stage;

    localparam int DW    = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        use_rt;
        logic        regwr;
        logic        memrd;
        logic        memwr;
        logic [1:0]  mtr;
        logic        alusrc;
        logic [5:0]  alufun;
        logic        branch;
    } instr_t;

    typedef struct packed {
        logic       stall_known;
        logic       stall;
        instr_t     nxt;
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset, Flush;
    instr_t din;
    instr_t act;
    logic [DW-1:0] PC4_ID_EX, DataA_ID_EX, DataB_ID_EX, Imm_ID_EX;
    logic [4:0] Rs_ID_EX, Rt_ID_EX, AddrC_ID_EX;
    logic UseRt_ID_EX, RegWr_ID_EX, MemRd_ID_EX, MemWr_ID_EX, ALUSrc_ID_EX, Branch_ID_EX;
    logic [1:0] MemToReg_ID_EX;
    logic [5:0] ALUFun_ID_EX;
    logic Stall;
    logic [CNT_W-1:0] StallCnt;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: the instruction sitting in EX and the counter
    instr_t m_ex;
    int     m_cnt;
    logic   m_known;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .PC4_ID(din.pc4), .DataA_ID(din.a), .DataB_ID(din.b), .Imm_ID(din.imm),
        .Rs_ID(din.rs), .Rt_ID(din.rt), .AddrC_ID(din.rd), .UseRt_ID(din.use_rt),
        .RegWr_ID(din.regwr), .MemRd_ID(din.memrd), .MemWr_ID(din.memwr),
        .ALUSrc_ID(din.alusrc), .Branch_ID(din.branch), .MemToReg_ID(din.mtr),
        .ALUFun_ID(din.alufun), .Flush(Flush),
        .PC4_ID_EX(PC4_ID_EX), .DataA_ID_EX(DataA_ID_EX), .DataB_ID_EX(DataB_ID_EX),
        .Imm_ID_EX(Imm_ID_EX), .Rs_ID_EX(Rs_ID_EX), .Rt_ID_EX(Rt_ID_EX),
        .AddrC_ID_EX(AddrC_ID_EX), .UseRt_ID_EX(UseRt_ID_EX), .RegWr_ID_EX(RegWr_ID_EX),
        .MemRd_ID_EX(MemRd_ID_EX), .MemWr_ID_EX(MemWr_ID_EX), .ALUSrc_ID_EX(ALUSrc_ID_EX),
        .Branch_ID_EX(Branch_ID_EX), .MemToReg_ID_EX(MemToReg_ID_EX),
        .ALUFun_ID_EX(ALUFun_ID_EX), .Stall(Stall), .StallCnt(StallCnt)
    );

    assign act = {PC4_ID_EX, DataA_ID_EX, DataB_ID_EX, Imm_ID_EX, Rs_ID_EX, Rt_ID_EX,
                  AddrC_ID_EX, UseRt_ID_EX, RegWr_ID_EX, MemRd_ID_EX, MemWr_ID_EX,
                  MemToReg_ID_EX, ALUSrc_ID_EX, ALUFun_ID_EX, Branch_ID_EX};

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic logic model_hazard(input instr_t id);
        // The EX load writes a real register the ID instruction needs next cycle
        return m_known && m_ex.memrd && (m_ex.rd != 5'd0) &&
               (m_ex.rd == id.rs || (id.use_rt && m_ex.rd == id.rt));
    endfunction

    // Drive one ID instruction for one cycle and queue what must follow
    task automatic step(input instr_t id, input logic fl, input logic rst_n);
        exp_t e;
        logic hz;
        @(negedge clk);
        din   = id;
        Flush = fl;
        reset = rst_n;
        hz = model_hazard(id);
        e.stall_known = m_known;
        e.stall = hz && !fl;
        if (!rst_n) begin
            m_ex = '0;
            m_cnt = 0;
            m_known = 1'b1;
        end else if (fl || hz) begin
            if (!fl) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
            m_ex = '0;
        end else begin
            m_ex = id;
        end
        e.nxt = m_ex;
        e.cnt = 4'(m_cnt);
        sb.push_back(e);
    endtask

    function automatic instr_t rand_instr();
        instr_t r;
        r.pc4 = $urandom; r.a = $urandom; r.b = $urandom; r.imm = $urandom;
        r.rs = 5'($urandom_range(0, 4));
        r.rt = 5'($urandom_range(0, 4));
        r.rd = 5'($urandom_range(0, 4));
        r.use_rt = 1'($urandom); r.regwr = 1'($urandom); r.memrd = 1'($urandom);
        r.memwr = 1'($urandom); r.mtr = 2'($urandom_range(0, 2)); r.alusrc = 1'($urandom);
        r.alufun = 6'($urandom); r.branch = 1'($urandom);
        return r;
    endfunction

    function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input logic use_rt, input logic memrd);
        instr_t r;
        r = '0;
        r.pc4 = 32'h0000_0040; r.a = 32'h0000_1234; r.b = 32'h0000_5678; r.imm = 32'h0000_0004;
        r.rs = rs; r.rt = rt; r.rd = rd; r.use_rt = use_rt;
        r.regwr = 1'b1; r.memrd = memrd; r.mtr = memrd ? 2'd1 : 2'd0;
        r.alusrc = memrd; r.alufun = 6'h20;
        return r;
    endfunction

    // Monitor: Stall is checked mid-cycle, the registers just after the edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb[0];
                if (e.stall_known) check("stall", 160'(Stall), 160'(e.stall));
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check("id_ex_regs", 160'(act), 160'(e.nxt));
                check("stall_cnt", 160'(StallCnt), 160'(e.cnt));
            end
        end
    end

    initial begin : driver
        instr_t cur;
        int guard;
        din = rand_instr(); Flush = 1'b0; reset = 1'b0;
        m_ex = '0; m_cnt = 0; m_known = 1'b0;
        // Reset with nonzero inputs, then reset state with Stall low
        step(rand_instr(), 1'b0, 1'b0);
        step(rand_instr(), 1'b1, 1'b0);
        // Pass-through
        step(mk(5'd3, 5'd4, 5'd5, 1'b1, 1'b0), 1'b0, 1'b1);
        // Load-use: lw $8, then add using $8 held for the stall cycle
        step(mk(5'd1, 5'd0, 5'd8, 1'b0, 1'b1), 1'b0, 1'b1);
        step(mk(5'd8, 5'd2, 5'd9, 1'b1, 1'b0), 1'b0, 1'b1);
        step(mk(5'd8, 5'd2, 5'd9, 1'b1, 1'b0), 1'b0, 1'b1);
        // Load to $0 never stalls
        step(mk(5'd1, 5'd0, 5'd0, 1'b0, 1'b1), 1'b0, 1'b1);
        step(mk(5'd0, 5'd0, 5'd3, 1'b1, 1'b0), 1'b0, 1'b1);
        // Rt match ignored when Rt is not read
        step(mk(5'd1, 5'd0, 5'd8, 1'b0, 1'b1), 1'b0, 1'b1);
        step(mk(5'd2, 5'd8, 5'd3, 1'b0, 1'b0), 1'b0, 1'b1);
        // Flush beats load-use
        step(mk(5'd1, 5'd0, 5'd8, 1'b0, 1'b1), 1'b0, 1'b1);
        step(mk(5'd8, 5'd2, 5'd9, 1'b1, 1'b0), 1'b1, 1'b1);
        // Reset in the middle of a stall
        step(mk(5'd1, 5'd0, 5'd8, 1'b0, 1'b1), 1'b0, 1'b1);
        step(mk(5'd8, 5'd2, 5'd9, 1'b1, 1'b0), 1'b0, 1'b0);
        step(mk(5'd8, 5'd2, 5'd9, 1'b1, 1'b0), 1'b0, 1'b1);
        // Saturation: 17 load-use stalls on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            step(mk(5'd1, 5'd0, 5'd8, 1'b0, 1'b1), 1'b0, 1'b1);
            step(mk(5'd8, 5'd2, 5'd9, 1'b1, 1'b0), 1'b0, 1'b1);
            step(mk(5'd8, 5'd2, 5'd9, 1'b1, 1'b0), 1'b0, 1'b1);
        end
        // Randomized stream; ID instruction is held while a stall is expected
        step(rand_instr(), 1'b0, 1'b0);
        cur = rand_instr();
        for (int i = 0; i < 400; i++) begin
            logic fl, rn, hold;
            fl = ($urandom_range(0, 7) == 0);
            rn = ($urandom_range(0, 49) != 0);
            hold = model_hazard(cur) && !fl && rn;
            step(cur, fl, rn);
            if (!hold) cur = rand_instr();
        end
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        check("scoreboard_drained", 160'(sb.size()), 160'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
